alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 116 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue controller for an external combinational ALU. It holds a small
//   register file, accepts one instruction at a time, and drives registered
//   operands to the ALU. It captures the ALU result one cycle later and
//   writes it back one cycle after that.
//   Each instruction takes three cycles: IDLE (accept), EXEC (capture), WB (write).
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       instruction handshake
//   in_op                   00 AND, 01 OR, 10 ADD, 11 SUB
//   in_rd/in_rs1/in_rs2     destination and source register indices
//   ld_en/ld_addr/ld_data   direct register load, allowed in any state
//   alu_op/alu_a/alu_b      registered opcode and operands to the ALU
//   alu_o/alu_cout          combinational ALU result and carry-out
//   res_valid               one-cycle write-back pulse
//   res_data/res_cout       captured ALU result and raw carry-out
//   carry_flag              sticky carry of the last ADD/SUB
//   dbg_addr/dbg_data       combinational register-file read port
module alu_issue_ctrl #(
    parameter int DATA_W = 16,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [AW-1:0]     in_rd,
    input  logic [AW-1:0]     in_rs1,
    input  logic [AW-1:0]     in_rs2,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_o,
    input  logic              alu_cout,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_cout,
    output logic              carry_flag,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t                        state, state_nxt;
    logic [DEPTH-1:0][DATA_W-1:0]  regs;
    logic [AW-1:0]                 rd_q;
    logic                          accept;

    assign accept    = (state == IDLE) && in_valid;
    assign in_ready  = rst_n && (state == IDLE);
    // Gated with rst_n so no pulse appears while reset is asserted in WB.
    assign res_valid = rst_n && (state == WB);
    assign dbg_data  = regs[dbg_addr];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath. Operand reads at accept see pre-edge register contents.
    // The WB write is placed after the direct load so it wins on an
    // address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs       <= '0;
            rd_q       <= '0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            res_data   <= '0;
            res_cout   <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            if (ld_en)
                regs[ld_addr] <= ld_data;
            if (accept) begin
                rd_q   <= in_rd;
                alu_op <= in_op;
                alu_a  <= regs[in_rs1];
                alu_b  <= regs[in_rs2];
            end
            if (state == EXEC) begin
                res_data <= alu_o;
                res_cout <= alu_cout;
            end
            if (state == WB) begin
                regs[rd_q] <= res_data;
                // Only arithmetic ops (ADD/SUB) update the sticky carry.
                if (alu_op[1])
                    carry_flag <= res_cout;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    localparam int DATA_W = 16;
    localparam int AW     = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [AW-1:0]     in_rd, in_rs1, in_rs2;
    logic              ld_en;
    logic [AW-1:0]     ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] alu_a, alu_b, alu_o;
    logic              alu_cout;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_cout;
    logic              carry_flag;
    logic [AW-1:0]     dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(DATA_W), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_o(alu_o), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_data(res_data), .res_cout(res_cout),
        .carry_flag(carry_flag),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Reference combinational ALU driving the DUT's alu_o/alu_cout.
    logic [DATA_W:0] sum_w;
    always_comb begin
        sum_w    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_o    = '0;
        alu_cout = 1'b0;
        case (alu_op)
            2'b00: alu_o = alu_a & alu_b;
            2'b01: alu_o = alu_a | alu_b;
            2'b10: begin alu_o = sum_w[DATA_W-1:0]; alu_cout = sum_w[DATA_W]; end
            default: begin alu_o = alu_a - alu_b; alu_cout = (alu_a >= alu_b); end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DATA_W-1:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, 32'(dbg_data), 32'(exp));
    endtask

    // Full issue: accept, EXEC, WB (optional direct load during WB), then
    // check the write-back data and the sticky carry.
    task automatic issue(input string tag, input logic [1:0] op,
                         input logic [AW-1:0] rd, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [DATA_W-1:0] exp_res, input logic exp_cf,
                         input logic wb_ld, input logic [AW-1:0] wb_addr, input logic [DATA_W-1:0] wb_data);
        chk({tag, ".ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        tick();                      // accept edge
        in_valid = 1'b0;
        chk({tag, ".exec_vld"}, 32'(res_valid), 32'd0);
        tick();                      // now in WB
        chk({tag, ".wb_vld"}, 32'(res_valid), 32'd1);
        chk({tag, ".res"}, 32'(res_data), 32'(exp_res));
        if (wb_ld) begin ld_en = 1'b1; ld_addr = wb_addr; ld_data = wb_data; end
        tick();
        ld_en = 1'b0;
        chk({tag, ".post_vld"}, 32'(res_valid), 32'd0);
        chk({tag, ".cf"}, 32'(carry_flag), 32'(exp_cf));
        rd_chk({tag, ".rd"}, rd, exp_res);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;

        // Reset state
        tick(); tick();
        chk("rst.vld_low", 32'(res_valid), 32'd0);
        chk("rst.ready_low", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) rd_chk($sformatf("rst.r%0d", i), AW'(i), 16'h0000);
        chk("rst.ready", 32'(in_ready), 32'd1);
        chk("rst.cf", 32'(carry_flag), 32'd0);
        chk("rst.vld", 32'(res_valid), 32'd0);

        // AND
        ld(3'd1, 16'h1234); ld(3'd2, 16'h00FF);
        issue("and", 2'b00, 3'd3, 3'd1, 3'd2, 16'h0034, 1'b0, 1'b0, 3'd0, 16'h0);

        // ADD with carry, OR keeps carry
        ld(3'd1, 16'hFFFF); ld(3'd2, 16'h0001);
        issue("add", 2'b10, 3'd4, 3'd1, 3'd2, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0);
        chk("add.cout", 32'(res_cout), 32'd1);
        issue("or", 2'b01, 3'd5, 3'd1, 3'd2, 16'hFFFF, 1'b1, 1'b0, 3'd0, 16'h0);

        // SUB borrow / no borrow; second one also loads r0 during WB
        ld(3'd1, 16'h0005); ld(3'd2, 16'h0007);
        issue("sub1", 2'b11, 3'd6, 3'd1, 3'd2, 16'hFFFE, 1'b0, 1'b0, 3'd0, 16'h0);
        issue("sub2", 2'b11, 3'd7, 3'd2, 3'd1, 16'h0002, 1'b1, 1'b1, 3'd0, 16'h5A5A);
        rd_chk("wb_ld_r0", 3'd0, 16'h5A5A);

        // Back-to-back dependent ADDs with in_valid held high
        ld(3'd1, 16'h0001); ld(3'd2, 16'h0002);
        in_valid = 1'b1; in_op = 2'b10; in_rd = 3'd3; in_rs1 = 3'd1; in_rs2 = 3'd2;
        tick();                                   // accept #1
        in_rd = 3'd4; in_rs1 = 3'd3; in_rs2 = 3'd3;
        chk("b2b.ready_e", 32'(in_ready), 32'd0);
        tick();
        chk("b2b.ready_w", 32'(in_ready), 32'd0);
        chk("b2b.res1", 32'(res_data), 32'h0003);
        tick();
        chk("b2b.ready_i", 32'(in_ready), 32'd1);
        rd_chk("b2b.r3", 3'd3, 16'h0003);
        tick();                                   // accept #2, 3 cycles later
        in_valid = 1'b0;
        chk("b2b.alu_a", 32'(alu_a), 32'h0003);
        tick();
        chk("b2b.wb_vld", 32'(res_valid), 32'd1);
        chk("b2b.res2", 32'(res_data), 32'h0006);
        ld_en = 1'b1; ld_addr = 3'd4; ld_data = 16'hAAAA;
        tick();
        ld_en = 1'b0;
        rd_chk("b2b.r4_wb_wins", 3'd4, 16'h0006);

        // Reset during EXEC aborts the instruction
        in_valid = 1'b1; in_op = 2'b01; in_rd = 3'd5; in_rs1 = 3'd1; in_rs2 = 3'd2;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("abort.vld_rst", 32'(res_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("abort.ready", 32'(in_ready), 32'd1);
        chk("abort.vld0", 32'(res_valid), 32'd0);
        tick();
        chk("abort.vld1", 32'(res_valid), 32'd0);
        rd_chk("abort.r5", 3'd5, 16'h0000);
        chk("abort.cf", 32'(carry_flag), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
